// File: rtl/prime_check.sv
// Trial-division primality tester that sequences an attached divmod unit over divisors 2, 3, 4, ...
// Define PRIME_ODD_ONLY_EN to skip even divisors above 2 (same results, fewer divisions).
module prime_check #(
  parameter  int WIDTH_LOG = 4,
  localparam int W         = 1 << WIDTH_LOG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] num,
  output logic         ready,
  output logic         is_prime,
  output logic [W-1:0] factor,
  output logic         error,
  output logic         dm_go,
  output logic [W-1:0] dm_num,
  output logic [W-1:0] dm_den,
  input  logic         dm_ready,
  input  logic         dm_error,
  input  logic [W-1:0] dm_quot,
  input  logic [W-1:0] dm_rem
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t       state, state_n;
  logic [W-1:0] num_q;
  logic [W-1:0] d;
  logic [W-1:0] next_d;
  logic         skip;
  logic         sample;

`ifdef PRIME_ODD_ONLY_EN
  assign next_d = (d == W'(2)) ? W'(3) : d + W'(2);
`else
  assign next_d = d + W'(1);
`endif

  // divmod's ready lags its go by a cycle, so the first WAIT cycle shows a stale ready.
  assign sample = (state == WAIT) && !skip && dm_ready;

  assign ready  = (state == IDLE);
  assign dm_num = num_q;
  assign dm_den = d;

  // NOTE: state_n and dm_go get defaults before the case so no path leaves them unassigned (no latch).
  always_comb begin
    state_n = state;
    dm_go   = 1'b0;
    case (state)
      IDLE:  if (go && num >= W'(4)) state_n = ISSUE;
      ISSUE: begin
        dm_go   = 1'b1;
        state_n = WAIT;
      end
      WAIT: if (sample) begin
        if (dm_error || dm_rem == '0 || dm_quot < d) state_n = IDLE;
        else                                          state_n = ISSUE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_prime <= 1'b0;
      factor   <= '0;
      error    <= 1'b0;
      num_q    <= '0;
      d        <= W'(2);
      skip     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          if (num < W'(4)) begin
            is_prime <= (num == W'(2)) || (num == W'(3));
            factor   <= '0;
            error    <= 1'b0;
          end else begin
            num_q <= num;
            d     <= W'(2);
            error <= 1'b0;
          end
        end
        ISSUE: skip <= 1'b1;
        WAIT: begin
          skip <= 1'b0;
          if (sample) begin
            if (dm_error) begin
              error    <= 1'b1;
              is_prime <= 1'b0;
              factor   <= '0;
            end else if (dm_rem == '0) begin
              is_prime <= 1'b0;
              factor   <= d;
            end else if (dm_quot < d) begin
              // d*d > num with no divisor found: num is prime
              is_prime <= 1'b1;
              factor   <= '0;
            end else begin
              d <= next_d;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
